// File: rtl/md_pkg.sv
// Shared definitions for the RV32M multiply/divide issue controller:
// funct3 encodings, controller state encoding, default timeout and
// the multiply/divide classifier.
package md_pkg;

  localparam int XLEN_DEFAULT    = 32;
  localparam int TIMEOUT_DEFAULT = 40;

  // M-extension funct3 encodings
  localparam logic [2:0] FN_MUL    = 3'b000;
  localparam logic [2:0] FN_MULH   = 3'b001;
  localparam logic [2:0] FN_MULHSU = 3'b010;
  localparam logic [2:0] FN_MULHU  = 3'b011;
  localparam logic [2:0] FN_DIV    = 3'b100;
  localparam logic [2:0] FN_DIVU   = 3'b101;
  localparam logic [2:0] FN_REM    = 3'b110;
  localparam logic [2:0] FN_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,  // nothing in flight
    DIV_WAIT = 2'd1,  // divide (or late multiply) running in the unit
    DRAIN    = 2'd2,  // flushed op still running; its result is dropped
    WB       = 2'd3   // result buffered, waiting for writeback
  } state_t;

  // Divides/remainders are the ops with funct3[2] set
  function automatic logic is_div(input logic [2:0] funct3);
    return funct3[2];
  endfunction

endpackage

// File: rtl/muldiv_issue.sv
// Initiator-side controller for the RV32M multiply/divide unit.
// Accepts one op from execute, starts the unit, holds operands while a
// divide runs, buffers the result for writeback and stalls the pipeline
// until the writeback is taken. Handles flushes and lost responses.
module muldiv_issue
  import md_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  // execute stage
  input  logic            ex_valid,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  output logic            stall,
  // mul/div unit
  output logic            md_start,
  output logic [2:0]      md_opcode,
  output logic [XLEN-1:0] md_rs1,
  output logic [XLEN-1:0] md_rs2,
  input  logic            md_busy,
  input  logic            md_ready,
  input  logic [XLEN-1:0] md_result,
  // writeback
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  input  logic            wb_ready,
  output logic            timeout_err
);

  // Wide enough to hold TIMEOUT-1 for any TIMEOUT >= 1
  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [2:0]       op_q;
  logic [XLEN-1:0]  rs1_q;
  logic [XLEN-1:0]  rs2_q;
  logic [4:0]       rd_q;
  logic [XLEN-1:0]  res_q;
  logic [CNT_W-1:0] cnt;
  logic             timeout_q;
  logic             accept;

  // The unit tracks its own busy state; sequencing relies only on md_ready.
  logic busy_unused;
  assign busy_unused = md_busy;

  // Accept an op only from IDLE and only when it is not being flushed.
  assign accept = (state == IDLE) && ex_valid && !flush;

  // NOTE: start and the operand mux are combinational so a multiply can be
  // answered by the unit in the same cycle it is accepted; outside the
  // accept cycle the unit sees the latched op, which stays stable until exit.
  assign md_start  = accept;
  assign md_opcode = accept ? ex_funct3 : op_q;
  assign md_rs1    = accept ? ex_rs1    : rs1_q;
  assign md_rs2    = accept ? ex_rs2    : rs2_q;

  assign stall       = (state != IDLE) || accept;
  assign wb_valid    = (state == WB);
  assign wb_rd       = rd_q;
  assign wb_data     = res_q;
  assign timeout_err = timeout_q;

  // Controller FSM with the op latch, result buffer and timeout counter.
  // NOTE: every register here is state, so only non-blocking assignments are
  // used; the datapath registers are reset too, because their reset value is
  // visible on md_* and wb_* outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      res_q     <= '0;
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= ex_funct3;
            rs1_q <= ex_rs1;
            rs2_q <= ex_rs2;
            rd_q  <= ex_rd;
            if (!is_div(ex_funct3) && md_ready) begin
              // multiply answered in the accept cycle
              res_q <= md_result;
              state <= WB;
            end else begin
              // divide, or a multiply the unit did not answer at once
              cnt   <= '0;
              state <= DIV_WAIT;
            end
          end
        end

        DIV_WAIT: begin
          if (flush) begin
            if (md_ready) begin
              // result arrived with the flush: simply drop it
              state <= IDLE;
            end else begin
              // the unit cannot be aborted; wait for it and discard
              cnt   <= '0;
              state <= DRAIN;
            end
          end else if (md_ready) begin
            res_q <= md_result;
            state <= WB;
          end else if (cnt == CNT_LAST) begin
            timeout_q <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        DRAIN: begin
          if (md_ready) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            timeout_q <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        WB: begin
          // flush wins over wb_ready; either way the buffer is released
          if (flush || wb_ready) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
